// File: rtl/mul_div_pkg.sv
// Shared constants and state encoding for the sequential HI/LO multiplier and divider.
package mul_div_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned ITER_LAST = 31;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFin
  } state_e;

endpackage

// File: rtl/twos_neg.sv
// Conditional two's-complement: data_o = en_i ? -data_i : data_i.
module twos_neg #(
  parameter int unsigned Width = 32
) (
  input  logic             en_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o
);

  assign data_o = en_i ? -data_i : data_i;

endmodule

// File: rtl/mul.sv
// Iterative radix-2 shift-add 32x32->64 multiplier for MULT/MULTU, with a
// start/done/busy handshake shared with the sequential divider.
module mul
  import mul_div_pkg::*;
#(
  parameter int unsigned Width = WIDTH,
  parameter int unsigned CntW  = CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             sign_i,
  input  logic [Width-1:0] data_a_i,
  input  logic [Width-1:0] data_b_i,
  output logic [Width-1:0] data_hi_o,
  output logic [Width-1:0] data_lo_o,
  output logic             done_o,
  output logic             busy_o
);

  state_e             state_q, state_d;
  logic [Width-1:0]   a_q, a_d, b_q, b_d;
  logic [Width-1:0]   a_mag, b_mag;
  logic [2*Width-1:0] acc_q, acc_d, prod;
  logic [Width:0]     sum;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [Width-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;

  twos_neg #(.Width(Width)) u_mag_a (
    .en_i   (sign_i & data_a_i[Width-1]),
    .data_i (data_a_i),
    .data_o (a_mag)
  );

  twos_neg #(.Width(Width)) u_mag_b (
    .en_i   (sign_i & data_b_i[Width-1]),
    .data_i (data_b_i),
    .data_o (b_mag)
  );

  twos_neg #(.Width(2 * Width)) u_prod (
    .en_i   (neg_q),
    .data_i (acc_q),
    .data_o (prod)
  );

  // Carry out of the upper half lands in the MSB after the right shift.
  assign sum = {1'b0, acc_q[2*Width-1:Width]} + (b_q[0] ? {1'b0, a_q} : '0);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          a_d     = a_mag;
          b_d     = b_mag;
          neg_d   = sign_i & (data_a_i[Width-1] ^ data_b_i[Width-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d = {sum, acc_q[Width-1:1]};
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(ITER_LAST)) begin
          state_d = StFin;
        end
      end
      StFin: begin
        {hi_d, lo_d} = prod;
        done_d       = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign data_hi_o = hi_q;
  assign data_lo_o = lo_q;
  assign done_o    = done_q;
  assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_mul.sv
// Scoreboard bench for mul: the driver queues expected products, a monitor checks each done.
module tb_mul;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] hi, lo;
  logic        done, busy;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_done = 0;
  logic        prev_done = 1'b0;
  logic [63:0] last_out = '0;

  mul u_dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .sign_i    (sign),
    .data_a_i  (a),
    .data_b_i  (b),
    .data_hi_o (hi),
    .data_lo_o (lo),
    .done_o    (done),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, req);
    end
  endtask

  // Monitor: compares every done pulse against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        exp_t e;
        n_done++;
        check("done_single_cycle", 64'(prev_done), 64'(0));
        check("busy_low_with_done", 64'(busy), 64'(0));
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got hi=0x%08h lo=0x%08h expected none", hi, lo);
        end else begin
          e = sb.pop_front();
          check("product", {hi, lo}, {e.hi, e.lo});
          check("latency", 64'(cyc - e.cyc), 64'(33));
        end
      end else if ({hi, lo} !== last_out) begin
        n_checks++;
        n_fail++;
        $display("FAIL output_hold: got 0x%08h%08h expected 0x%016h", hi, lo, last_out);
      end
    end
    prev_done = done;
    last_out  = {hi, lo};
  end

  task automatic issue(input logic sg, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] ehi, input logic [31:0] elo);
    @(negedge clk);
    start = 1'b1;
    sign  = sg;
    a     = va;
    b     = vb;
    @(posedge clk);
    #1;
    sb.push_back('{hi: ehi, lo: elo, cyc: cyc});
    start = 1'b0;
    check("busy_after_accept", 64'(busy), 64'(1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_out", {hi, lo}, 64'(0));
    check("reset_flags", {62'(0), done, busy}, 64'(0));
    rst_n = 1'b1;

    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    wait_idle();
    issue(1'b1, 32'hFFFF_FF01, 32'h0000_0030, 32'hFFFF_FFFF, 32'hFFFF_D030);
    wait_idle();
    issue(1'b0, 32'hFFFF_FF01, 32'h0000_0030, 32'h0000_002F, 32'hFFFF_D030);
    wait_idle();
    issue(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    wait_idle();
    issue(1'b1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000);
    wait_idle();
    issue(1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_000F);
    wait_idle();

    // Zero operand with an ignored start pulse while busy.
    issue(1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000);
    repeat (5) @(negedge clk);
    start = 1'b1;
    sign  = 1'b0;
    a     = 32'd5;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Back-to-back: start held across done, operands changed while busy.
    @(negedge clk);
    start = 1'b1;
    sign  = 1'b0;
    a     = 32'd6;
    b     = 32'd7;
    @(posedge clk);
    #1;
    sb.push_back('{hi: 32'h0, lo: 32'd42, cyc: cyc});
    a = 32'd3;
    b = 32'd4;
    begin
      int n = 0;
      while (!done && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    @(posedge clk);
    #1;
    sb.push_back('{hi: 32'h0, lo: 32'd12, cyc: cyc});
    check("busy_after_b2b_accept", 64'(busy), 64'(1));
    start = 1'b0;
    wait_idle();

    // Reset ten edges into an operation: no result, everything back to zero.
    issue(1'b0, 32'd2, 32'd3, 32'h0, 32'd6);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midop_reset_out", {hi, lo}, 64'(0));
    check("midop_reset_flags", {62'(0), done, busy}, 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(1'b0, 32'd2, 32'd3, 32'h0, 32'd6);
    wait_idle();

    check("done_count", 64'(n_done), 64'(10));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
